// File: rtl/bcd_updown_counter_param.sv
// Multi-digit BCD up/down counter with tick divider, run toggle,
// validated parallel load and one-cycle wrap / load-error pulses.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   key_run   debounced run/pause key; rising edge toggles run
//   dir       0 = count up, 1 = count down (sampled on tick)
//   load      one-cycle load strobe
//   load_val  BCD value to load (W = 4*DIGITS bits)
//   cnt_out   BCD count, nibble 0 = least-significant digit
//   run       1 = counting, 0 = paused
//   wrap      one-cycle pulse on wrap-around
//   load_err  one-cycle pulse when a load is rejected
module bcd_updown_counter_param #(
    parameter int                  DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] MAX_BCD = 'h30,
    parameter int                  DIV_MAX = 5_000_000,
    parameter int                  DIV_W   = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_run,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt_out,
    output logic                  run,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

    logic [DIV_W-1:0] div;
    logic             key_q;
    logic             tick;
    logic             key_edge;
    logic             load_ok;

    // Every nibble must be a decimal digit.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // BCD +1 with ripple carry; caller guarantees v < MAX_BCD.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with ripple borrow; caller guarantees v > 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick     = (div == DIV_LAST);
    assign key_edge = key_run & ~key_q;
    // With all nibbles valid, binary order equals BCD order.
    assign load_ok  = bcd_valid(load_val) && (load_val <= MAX_BCD);

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            key_q    <= 1'b0;
            run      <= 1'b1;
            cnt_out  <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            key_q    <= key_run;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            div      <= tick ? '0 : div + 1'b1;

            // Step below still sees the pre-toggle run value.
            if (key_edge) begin
                run <= ~run;
            end

            if (load) begin
                // A load swallows any coincident tick.
                if (load_ok) begin
                    cnt_out <= load_val;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick && run) begin
                if (!dir) begin
                    if (cnt_out == MAX_BCD) begin
                        cnt_out <= '0;
                        wrap    <= 1'b1;
                    end else begin
                        cnt_out <= bcd_inc(cnt_out);
                    end
                end else begin
                    if (cnt_out == '0) begin
                        cnt_out <= MAX_BCD;
                        wrap    <= 1'b1;
                    end else begin
                        cnt_out <= bcd_dec(cnt_out);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_param.sv
// Scoreboard bench for bcd_updown_counter_param (DIV_MAX=4, 2 digits,
// ceiling 'h30); expected output events are queued by the stimulus.
module tb_bcd_updown_counter_param;

    typedef struct packed {
        logic [7:0] cnt;
        logic       run;
        logic       wrap;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_run = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] cnt_out;
    logic       run;
    logic       wrap;
    logic       load_err;

    logic [1:0] ph;
    logic       mon_en = 1'b0;
    exp_t       q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    bcd_updown_counter_param #(
        .DIGITS  (2),
        .MAX_BCD (8'h30),
        .DIV_MAX (4),
        .DIV_W   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_run  (key_run),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .cnt_out  (cnt_out),
        .run      (run),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    // Divider phase as seen by the bench: 3 means next edge is a tick.
    always @(posedge clk) begin
        if (rst) ph <= 2'd0;
        else     ph <= ph + 2'd1;
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push(input logic [7:0] c, input logic r,
                        input logic w, input logic e);
        exp_t x;
        x.cnt  = c;
        x.run  = r;
        x.wrap = w;
        x.err  = e;
        q.push_back(x);
    endtask

    task automatic to_tick();
        while (ph != 2'd3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            to_tick();
            @(negedge clk);
        end
    endtask

    task automatic press();
        key_run = 1'b1;
        @(negedge clk);
        key_run = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        @(negedge clk);
    endtask

    task automatic check();
        exp_t a;
        exp_t e;
        a.cnt  = cnt_out;
        a.run  = run;
        a.wrap = wrap;
        a.err  = load_err;
        n_vec++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL vec%0d unexpected: got cnt=%h run=%b wrap=%b err=%b, required none",
                     n_vec, a.cnt, a.run, a.wrap, a.err);
        end else begin
            e = q.pop_front();
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d: got cnt=%h run=%b wrap=%b err=%b, required cnt=%h run=%b wrap=%b err=%b",
                         n_vec, a.cnt, a.run, a.wrap, a.err,
                         e.cnt, e.run, e.wrap, e.err);
            end
        end
    endtask

    // Monitor: an output event is any change of cnt_out/run or a pulse.
    initial begin
        logic [7:0] p_cnt;
        logic       p_run;
        wait (mon_en);
        @(negedge clk);
        check();
        p_cnt = cnt_out;
        p_run = run;
        forever begin
            @(negedge clk);
            if (cnt_out !== p_cnt || run !== p_run || wrap || load_err) begin
                check();
            end
            p_cnt = cnt_out;
            p_run = run;
        end
    end

    initial begin
        exp_t e;
        // Reset state
        repeat (3) @(negedge clk);
        push(8'h00, 1'b1, 1'b0, 1'b0);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Free-run up 00..30, wrap to 00
        for (int v = 1; v <= 30; v++) push(bcd(v), 1'b1, 1'b0, 1'b0);
        push(8'h00, 1'b1, 1'b1, 1'b0);
        ticks(31);

        // Load 19 on a tick cycle with dir=1, count down, wrap to 30
        to_tick();
        push(8'h19, 1'b1, 1'b0, 1'b0);
        load_val = 8'h19;
        load     = 1'b1;
        dir      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int v = 18; v >= 0; v--) push(bcd(v), 1'b1, 1'b0, 1'b0);
        push(8'h30, 1'b1, 1'b1, 1'b0);
        ticks(20);

        // Pause at 12 for 20 ticks, resume to 13
        to_tick();
        push(8'h11, 1'b1, 1'b0, 1'b0);
        load_val = 8'h11;
        load     = 1'b1;
        dir      = 1'b0;
        @(negedge clk);
        load = 1'b0;
        push(8'h12, 1'b1, 1'b0, 1'b0);
        ticks(1);
        push(8'h12, 1'b0, 1'b0, 1'b0);
        press();
        ticks(20);
        push(8'h12, 1'b1, 1'b0, 1'b0);
        press();
        push(8'h13, 1'b1, 1'b0, 1'b0);
        ticks(1);

        // Rejected and accepted loads while paused
        push(8'h13, 1'b0, 1'b0, 1'b0);
        press();
        push(8'h13, 1'b0, 1'b0, 1'b1);
        do_load(8'h1A);
        push(8'h13, 1'b0, 1'b0, 1'b1);
        do_load(8'h31);
        push(8'h30, 1'b0, 1'b0, 1'b0);
        do_load(8'h30);

        // Resume on a tick edge (old run wins), then load on tick
        to_tick();
        push(8'h30, 1'b1, 1'b0, 1'b0);
        press();
        to_tick();
        push(8'h05, 1'b1, 1'b0, 1'b0);
        load_val = 8'h05;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push(8'h06, 1'b1, 1'b0, 1'b0);
        ticks(1);

        // Reset mid-count at 27 while paused
        push(8'h06, 1'b0, 1'b0, 1'b0);
        press();
        push(8'h27, 1'b0, 1'b0, 1'b0);
        do_load(8'h27);
        push(8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset with key_run held high: run drops right after release
        key_run = 1'b1;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        key_run = 1'b0;
        repeat (12) @(negedge clk);

        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL missing event: got none, required cnt=%h run=%b wrap=%b err=%b",
                     e.cnt, e.run, e.wrap, e.err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
